// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_t : fetch FSM state encoding (IDLE/REQ/WAIT/HOLD)
//   - INSTR_W       : instruction word width
//   - *_MSB/*_LSB   : bit positions of the Cond, Op, Funct and Rd fields
// -----------------------------------------------------------------------------
package arm_pkg;

  localparam int INSTR_W = 32;

  // Instruction field positions
  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 25;
  localparam int FUNCT_LSB = 20;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // first cycle after reset release
    REQ  = 2'd1,  // request asserted, waiting for grant
    WAIT = 2'd2,  // granted, waiting for read data
    HOLD = 2'd3   // instruction presented, waiting for decode handshake
  } fetch_state_t;

endpackage : arm_pkg

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
// Program counter register with +4 incrementer and redirect mux.
// A redirect has priority over a sequential advance. The redirect target is
// forced word-aligned; the increment wraps modulo 2^ADDR_W.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, loads RESET_PC
//   redirect  in   load the aligned target this edge
//   advance   in   step to pc + 4 this edge (ignored when redirect=1)
//   target    in   redirect address, bits [1:0] are dropped
//   pc        out  current fetch address
// -----------------------------------------------------------------------------
module fetch_pc #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic              advance,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d = pc;
    if (redirect) begin
      pc_d = target & ALIGN_MASK;
    end else if (advance) begin
      pc_d = pc + PC_STEP;  // natural wrap at 2^ADDR_W
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_d;
    end
  end

endmodule : fetch_pc

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Single-outstanding instruction fetch front end. Requests a word at PC,
// waits for read data, holds the instruction for the decode stage until it
// is accepted, then advances PC by 4. A redirect (PCSrc) in any state other
// than IDLE reloads PC; a read already in flight is squashed.
//
// Ports
//   clk, rst_n    clock and asynchronous active-low reset
//   ImemReq       out  read request (asserted in REQ)
//   ImemAddr      out  word-aligned fetch address (the PC)
//   ImemGnt       in   request accepted this cycle
//   ImemRvalid    in   read data valid (ignored outside WAIT)
//   ImemRdata     in   read data
//   Instr         out  buffered instruction
//   Cond/Op/Funct/Rd  out  slices of Instr
//   InstrPC       out  address of Instr
//   InstrValid    out  Instr is valid (asserted in HOLD)
//   InstrReady    in   decode accepts Instr
//   PCSrc         in   redirect request
//   BranchTarget  in   redirect address, bits [1:0] ignored
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import arm_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ImemReq,
  output logic [ADDR_W-1:0]  ImemAddr,
  input  logic               ImemGnt,
  input  logic               ImemRvalid,
  input  logic [INSTR_W-1:0] ImemRdata,
  output logic [INSTR_W-1:0] Instr,
  output logic [3:0]         Cond,
  output logic [1:0]         Op,
  output logic [5:0]         Funct,
  output logic [3:0]         Rd,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               PCSrc,
  input  logic [ADDR_W-1:0]  BranchTarget
);

  fetch_state_t      state_q, state_d;
  logic              squash_q, squash_d;  // discard the next read data
  logic              capture;             // load the instruction buffer
  logic              redirect;
  logic              advance;
  logic [ADDR_W-1:0] pc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;

  // IDLE is the only state where a redirect is not honoured.
  assign redirect = PCSrc && (state_q != IDLE);
  // A handshake in HOLD steps PC; a simultaneous redirect wins inside fetch_pc.
  assign advance  = (state_q == HOLD) && InstrReady;

  fetch_pc #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_fetch_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .redirect(redirect),
    .advance (advance),
    .target  (BranchTarget),
    .pc      (pc)
  );

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        // Redirect without grant simply stays here and re-requests at the
        // new PC. With a grant the read in flight belongs to the old path.
        if (ImemGnt) begin
          state_d  = WAIT;
          squash_d = PCSrc;
        end
      end
      WAIT: begin
        if (PCSrc) begin
          if (ImemRvalid) begin
            state_d  = REQ;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (ImemRvalid) begin
          squash_d = 1'b0;
          if (squash_q) begin
            state_d = REQ;
          end else begin
            state_d = HOLD;
            capture = 1'b1;
          end
        end
      end
      HOLD: begin
        if (PCSrc || InstrReady) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
    end
  end

  // Instruction buffer: written only when fresh data is accepted, so it stays
  // stable throughout HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (capture) begin
      instr_q    <= ImemRdata;
      instr_pc_q <= pc;
    end
  end

  assign ImemReq    = (state_q == REQ);
  assign ImemAddr   = pc;
  assign InstrValid = (state_q == HOLD);
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;

  assign Cond  = instr_q[COND_MSB:COND_LSB];
  assign Op    = instr_q[OP_MSB:OP_LSB];
  assign Funct = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign Rd    = instr_q[RD_MSB:RD_LSB];

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed scenarios for the fetch timing corner cases, then a randomized run
// against a transaction-level model: an expected PC that follows redirects
// and accepted instructions, and a memory whose contents are a fixed function
// of the address.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gnt, rvalid, ready, pcsrc;
  logic [31:0] rdata, target;

  logic        req;
  logic [31:0] addr, instr, instr_pc;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        valid;

  logic        w_req;
  logic [31:0] w_addr, w_instr, w_instr_pc;
  logic [3:0]  w_cond, w_rd;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ImemReq(req), .ImemAddr(addr), .ImemGnt(gnt), .ImemRvalid(rvalid),
    .ImemRdata(rdata), .Instr(instr), .Cond(cond), .Op(op), .Funct(funct),
    .Rd(rd), .InstrPC(instr_pc), .InstrValid(valid), .InstrReady(ready),
    .PCSrc(pcsrc), .BranchTarget(target)
  );

  // Second instance starting at the top of the address space, driven by the
  // same inputs; only checked during the first directed scenario.
  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .ImemReq(w_req), .ImemAddr(w_addr), .ImemGnt(gnt), .ImemRvalid(rvalid),
    .ImemRdata(rdata), .Instr(w_instr), .Cond(w_cond), .Op(w_op),
    .Funct(w_funct), .Rd(w_rd), .InstrPC(w_instr_pc), .InstrValid(w_valid),
    .InstrReady(ready), .PCSrc(pcsrc), .BranchTarget(target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Memory contents: multiplication by an odd constant is a bijection, so
  // distinct addresses always hold distinct words.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc, out_addr, tgt, w;
    logic        outstanding, prev_req, prev_gnt, en_redirect;
    logic [31:0] prev_addr;
    int          wait_cnt, n_acc, stall, n_cyc;

    // ---------------- reset state ----------------
    rst_n = 1'b0; gnt = 1'b1; rvalid = 1'b0; rdata = '0;
    ready = 1'b1; pcsrc = 1'b0; target = '0;
    step(); step();
    check("rst_req",      32'(req), 32'd0);
    check("rst_addr",     addr, 32'h0);
    check("rst_instr",    instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_valid",    32'(valid), 32'd0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

    // ---------------- first fetch, immediate grant ----------------
    rst_n = 1'b1;
    step();  // cycle 1: IDLE -> REQ
    check("f1_req",  32'(req), 32'd1);
    check("f1_addr", addr, 32'h0);
    check("f1_wrap_addr", w_addr, 32'hFFFF_FFFC);
    step();  // cycle 2: granted
    check("f1_wait_req", 32'(req), 32'd0);
    rvalid = 1'b1; rdata = 32'hE081_2003;
    step();  // cycle 3: data registered
    rvalid = 1'b0;
    check("f1_valid",    32'(valid), 32'd1);
    check("f1_instr",    instr, 32'hE081_2003);
    check("f1_cond",     32'(cond), 32'hE);
    check("f1_op",       32'(op), 32'h0);
    check("f1_funct",    32'(funct), 32'b001000);
    check("f1_rd",       32'(rd), 32'h2);
    check("f1_instr_pc", instr_pc, 32'h0);
    check("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    step();  // handshake
    check("f1_next_req",  32'(req), 32'd1);
    check("f1_next_addr", addr, 32'h4);
    check("wrap_next_req",  32'(w_req), 32'd1);
    check("wrap_next_addr", w_addr, 32'h0);

    // ---------------- decode stall in HOLD ----------------
    step();  // grant of address 4
    rvalid = 1'b1; rdata = 32'h1A2B_3C4D; ready = 1'b0;
    step();
    rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(valid), 32'd1);
      check("stall_instr", instr, 32'h1A2B_3C4D);
      check("stall_req",   32'(req), 32'd0);
      step();
    end
    ready = 1'b1;
    check("stall_valid6", 32'(valid), 32'd1);
    check("stall_pc6",    instr_pc, 32'h4);
    step();
    check("stall_next_req",  32'(req), 32'd1);
    check("stall_next_addr", addr, 32'h8);

    // ---------------- redirect during WAIT ----------------
    step();  // grant of address 8
    pcsrc = 1'b1; target = 32'h0000_0103;
    step();
    pcsrc = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    check("wr_valid_a", 32'(valid), 32'd0);
    check("wr_req_a",   32'(req), 32'd0);
    step();  // stale data discarded
    rvalid = 1'b0;
    check("wr_valid_b", 32'(valid), 32'd0);
    check("wr_req_b",   32'(req), 32'd1);
    check("wr_addr",    addr, 32'h0000_0100);

    // ---------------- redirect with handshake in HOLD ----------------
    step();  // grant of 0x100
    rvalid = 1'b1; rdata = 32'h55AA_00FF;
    step();
    rvalid = 1'b0;
    check("hr_valid",    32'(valid), 32'd1);
    check("hr_instr_pc", instr_pc, 32'h100);
    check("hr_instr",    instr, 32'h55AA_00FF);
    ready = 1'b1; pcsrc = 1'b1; target = 32'h40;
    step();
    pcsrc = 1'b0;
    check("hr_valid_after", 32'(valid), 32'd0);
    check("hr_req",  32'(req), 32'd1);
    check("hr_addr", addr, 32'h40);

    // ---------------- reset during WAIT ----------------
    step();  // grant of 0x40
    gnt = 1'b0;
    check("rw_wait_req", 32'(req), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rw_rst_req",   32'(req), 32'd0);
    check("rw_rst_valid", 32'(valid), 32'd0);
    check("rw_rst_addr",  addr, 32'h0);
    step();
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    step();  // late rvalid in IDLE
    check("rw_req1",   32'(req), 32'd1);
    check("rw_addr1",  addr, 32'h0);
    check("rw_valid1", 32'(valid), 32'd0);
    step();  // late rvalid in REQ
    rvalid = 1'b0;
    check("rw_req2",   32'(req), 32'd1);
    check("rw_addr2",  addr, 32'h0);
    check("rw_valid2", 32'(valid), 32'd0);

    // ---------------- randomized run ----------------
    rst_n = 1'b0;
    step();
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0; pcsrc = 1'b0; target = '0;
    rst_n = 1'b1;
    exp_pc = 32'h0; outstanding = 1'b0; out_addr = '0; wait_cnt = 0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0;
    n_acc = 0; stall = 0; n_cyc = 0; en_redirect = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_cyc++;
      en_redirect = (n_cyc > 2);

      // Grant taken at the previous rising edge opens a memory transaction.
      if (prev_req && prev_gnt) begin
        outstanding = 1'b1;
        out_addr    = prev_addr;
        wait_cnt    = $urandom_range(0, 2);
      end

      if (req) begin
        check("rand_addr", addr, exp_pc);
        check("rand_single_outstanding", 32'(outstanding), 32'd0);
      end
      if (valid) begin
        w = mem_word(exp_pc);
        check("rand_instr_pc", instr_pc, exp_pc);
        check("rand_instr",    instr, w);
        check("rand_op",       32'(op), 32'(w[27:26]));
        check("rand_funct",    32'(funct), 32'(w[25:20]));
        check("rand_req_in_hold", 32'(req), 32'd0);
      end

      // Memory response
      if (outstanding) begin
        if (wait_cnt == 0) begin
          rvalid = 1'b1;
          rdata  = mem_word(out_addr);
          outstanding = 1'b0;
        end else begin
          wait_cnt--;
          rvalid = 1'b0;
        end
      end else begin
        rvalid = ($urandom_range(0, 9) == 0);  // stray beat, must be ignored
        rdata  = $urandom;
      end
      gnt   = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 1) == 1);
      pcsrc = en_redirect && ($urandom_range(0, 7) == 0);
      tgt   = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      target = tgt;

      // Reference model for the coming edge.
      if (valid && ready) begin
        n_acc++;
        stall = 0;
      end else begin
        stall++;
      end
      if (pcsrc) begin
        exp_pc = tgt & 32'hFFFF_FFFC;
      end else if (valid && ready) begin
        exp_pc = exp_pc + 32'd4;
      end

      prev_req  = req;
      prev_gnt  = gnt;
      prev_addr = addr;

      if (stall > 300) begin
        check("rand_progress_timeout", 32'(stall), 32'd0);
        break;
      end
    end
    check("rand_enough_accepted", 32'(n_acc >= 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch_unit

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter ADDR_W, default 32: PC and memory address width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ImemReq  out  1  instruction memory read request.
REQ-006 ImemAddr  out  ADDR_W  word-aligned fetch address; valid while ImemReq=1.
REQ-007 ImemGnt  in  1  memory accepts the request in this cycle.
REQ-008 ImemRvalid  in  1  read data valid; arrives at least one cycle after grant.
REQ-009 ImemRdata  in  32  fetched instruction word.
REQ-010 Instr  out  32  buffered instruction presented to the decode stage.
REQ-011 Cond  out  4  Instr[31:28].
REQ-012 Op  out  2  Instr[27:26], drives decoder Op.
REQ-013 Funct  out  6  Instr[25:20]; Funct[5] and Funct[0] drive the decoder Funct5 and Funct0 inputs.
REQ-014 Rd  out  4  Instr[15:12].
REQ-015 InstrPC  out  ADDR_W  address of the presented instruction.
REQ-016 InstrValid  out  1  Instr and its fields are valid.
REQ-017 InstrReady  in  1  decode stage accepts the instruction when InstrValid=1.
REQ-018 PCSrc  in  1  redirect request (taken branch or PC write).
REQ-019 BranchTarget  in  ADDR_W  redirect address; bits [1:0] are ignored and treated as 0.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, HOLD; the unit keeps at most one memory transaction outstanding.
REQ-021 IDLE -> REQ unconditionally on the first clock after reset release.
REQ-022 REQ: ImemReq=1 and ImemAddr=PC; ImemReq holds until ImemGnt=1, then the FSM goes to WAIT.
REQ-023 WAIT: on ImemRvalid=1, the unit registers ImemRdata into Instr and PC into InstrPC, then goes to HOLD (InstrValid=1 the next cycle) unless the squash flag is set.
REQ-024 HOLD: InstrValid=1; Instr, fields and InstrPC stay stable until InstrValid&InstrReady; then PC<=PC+4, InstrValid<=0, and the FSM goes to REQ.
REQ-025 Minimum fetch period is 3 cycles per instruction: grant cycle, rvalid cycle, handshake cycle.
REQ-026 PC+4 wraps modulo 2^ADDR_W, so 32'hFFFF_FFFC is followed by 0.
REQ-027 PCSrc=1 in any non-IDLE state loads PC<={BranchTarget[ADDR_W-1:2],2'b00} on that edge.
REQ-028 Redirect in REQ without ImemGnt: the next cycle re-requests at the target; no transaction is counted.
REQ-029 Redirect in REQ with ImemGnt the same cycle: go to WAIT with squash set.
REQ-030 Redirect in WAIT: set squash; the next ImemRvalid is discarded, squash clears, and the FSM goes to REQ.
REQ-031 Redirect with ImemRvalid in the same WAIT cycle: the data is discarded and the FSM goes to REQ.
REQ-032 Redirect in HOLD: InstrValid<=0 and the FSM goes to REQ; if InstrReady=1 the same cycle, the handshake still counts as accepted, but PC takes the target and not PC+4.
REQ-033 ImemRvalid outside WAIT is ignored.
REQ-034 Field outputs are pure slices of the registered Instr, with no extra latency.

Reset
REQ-035 While rst_n=0: ImemReq=0, ImemAddr=RESET_PC, Instr=0, InstrPC=0, InstrValid=0, squash=0, FSM=IDLE, PC=RESET_PC.
REQ-036 Reset asserted mid-transaction abandons that transaction; a late ImemRvalid after release is ignored per REQ-033.

Structure
REQ-037 Package arm_pkg holds fetch_state_t (IDLE/REQ/WAIT/HOLD), the field bit-position constants (COND, OP, FUNCT, RD) and INSTR_W=32.
REQ-038 One sub-module, fetch_pc, holds the PC register, the +4 incrementer and the redirect mux; the FSM and instruction buffer stay in the top module.

Verification
REQ-039 Reset release, memory grants immediately with rvalid 1 cycle later, ImemRdata=32'hE081_2003, InstrReady=1 -> InstrValid on cycle 3, Op=2'b00, Funct=6'b001000, Rd=4'h2, InstrPC=0, next ImemAddr=4.
REQ-040 InstrReady held 0 for 5 cycles in HOLD -> Instr/InstrValid stable, ImemReq=0 throughout; accepted on cycle 6, followed by a request at PC+4.
REQ-041 PCSrc=1 with BranchTarget=32'h0000_0103 during WAIT -> returned word discarded, InstrValid stays 0, next ImemAddr=32'h0000_0100.
REQ-042 RESET_PC=32'hFFFF_FFFC, one accepted instruction -> next ImemAddr=0.
REQ-043 PCSrc and InstrValid&InstrReady in the same HOLD cycle with BranchTarget=32'h40 -> one instruction consumed, next ImemAddr=32'h40.
REQ-044 rst_n pulsed low during WAIT, ImemRvalid arriving 1 cycle after release -> ignored, IDLE then REQ at RESET_PC.
